// File: rtl/uart_rx_word_assembler.sv
// uart_rx_word_assembler
// Collects NBYTES received bytes, first byte in the most significant position,
// into one wide word and then drops TAIL_BYTES trailer bytes. The word goes to
// the consumer through a valid/ready handshake. A frame that stalls for too
// long between bytes is aborted. A completed word that finds the previous word
// still unconsumed is dropped and flagged as an overrun.
module uart_rx_word_assembler #(
   parameter int NBYTES      = 16,
   parameter int TAIL_BYTES  = 1,
   parameter int TIMEOUT_CYC = 1250000
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic [7:0]            rx_byte,
   input  logic                  rx_valid,
   output logic [8*NBYTES-1:0]   word_o,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic [7:0]            byte_cnt,
   output logic                  timeout_err,
   output logic                  overrun_err
);

   localparam int W  = 8 * NBYTES;
   localparam int TW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);

   localparam logic [TW-1:0] TO_LIM    = TW'(TIMEOUT_CYC);
   localparam logic [7:0]    NB_LAST   = 8'(NBYTES - 1);
   localparam logic [15:0]   TAIL_LAST = 16'(TAIL_BYTES - 1);
   localparam bit            TO_EN     = (TIMEOUT_CYC > 0);
   localparam bit            ONE_BYTE  = (NBYTES == 1);
   localparam bit            HAS_TAIL  = (TAIL_BYTES > 0);
   localparam bit            ONE_TAIL  = (TAIL_BYTES == 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      COLLECT  = 2'd1,
      COMPLETE = 2'd2,
      TAIL     = 2'd3
   } state_t;

   state_t         state;
   logic [W-1:0]   sr;
   logic [TW-1:0]  timer;
   logic [15:0]    tail_cnt;
   logic           timeout_hit;

   // Append one byte at the low end of the shift register.
   // This works for any NBYTES, including 1.
   function automatic logic [W-1:0] shift_in(input logic [W-1:0] cur, input logic [7:0] b);
      logic [W+7:0] tmp;
      tmp = {cur, b};
      return tmp[W-1:0];
   endfunction

   // The inter-byte timeout is reached when the timer is at its limit and no byte arrives this cycle.
   assign timeout_hit = TO_EN && (timer == TO_LIM) && !rx_valid;

   // Frame FSM, shift register, output word register and error pulses.
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= IDLE;
         sr          <= '0;
         word_o      <= '0;
         word_valid  <= 1'b0;
         byte_cnt    <= 8'd0;
         timer       <= '0;
         tail_cnt    <= 16'd0;
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;
      end else begin
         timeout_err <= 1'b0;
         overrun_err <= 1'b0;

         // A handshake releases the word. The COMPLETE branch below may reload it in the same cycle.
         if (word_valid && word_ready) begin
            word_valid <= 1'b0;
         end else begin
            word_valid <= word_valid;
         end

         case (state)
            IDLE: begin
               timer <= '0;
               if (rx_valid) begin
                  sr       <= shift_in(sr, rx_byte);
                  byte_cnt <= 8'd1;
                  state    <= ONE_BYTE ? COMPLETE : COLLECT;
               end else begin
                  state <= IDLE;
               end
            end

            COLLECT: begin
               if (rx_valid) begin
                  sr       <= shift_in(sr, rx_byte);
                  byte_cnt <= byte_cnt + 8'd1;
                  timer    <= '0;
                  if (byte_cnt == NB_LAST) begin
                     state <= COMPLETE;
                  end else begin
                     state <= COLLECT;
                  end
               end else if (timeout_hit) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
                  byte_cnt    <= 8'd0;
                  sr          <= '0;
                  timer       <= '0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            COMPLETE: begin
               if (!word_valid || word_ready) begin
                  word_o     <= sr;
                  word_valid <= 1'b1;
               end else begin
                  overrun_err <= 1'b1;
               end
               byte_cnt <= 8'd0;
               timer    <= '0;
               tail_cnt <= 16'd0;
               if (HAS_TAIL) begin
                  // A byte arriving now is the first trailer byte.
                  if (rx_valid) begin
                     tail_cnt <= 16'd1;
                     state    <= ONE_TAIL ? IDLE : TAIL;
                  end else begin
                     state <= TAIL;
                  end
               end else begin
                  // With no trailer, a byte arriving now opens the next frame.
                  if (rx_valid) begin
                     sr       <= shift_in(sr, rx_byte);
                     byte_cnt <= 8'd1;
                     state    <= ONE_BYTE ? COMPLETE : COLLECT;
                  end else begin
                     state <= IDLE;
                  end
               end
            end

            TAIL: begin
               if (rx_valid) begin
                  timer <= '0;
                  if (tail_cnt == TAIL_LAST) begin
                     tail_cnt <= 16'd0;
                     state    <= IDLE;
                  end else begin
                     tail_cnt <= tail_cnt + 16'd1;
                     state    <= TAIL;
                  end
               end else if (timeout_hit) begin
                  timeout_err <= 1'b1;
                  state       <= IDLE;
                  byte_cnt    <= 8'd0;
                  sr          <= '0;
                  timer       <= '0;
                  tail_cnt    <= 16'd0;
               end else begin
                  timer <= timer + TW'(1);
               end
            end

            default: begin
               state    <= IDLE;
               byte_cnt <= 8'd0;
               timer    <= '0;
               tail_cnt <= 16'd0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_word_assembler.sv
// Directed self-checking bench for uart_rx_word_assembler.
// Instance a uses a short configuration (2 data bytes, 1 trailer byte, 20-cycle timeout).
// Instance b uses 16 data bytes and no trailer.
module tb_uart_rx_word_assembler;

   logic         clk = 1'b0;
   logic         reset_n;

   logic [7:0]   rx_byte_a, rx_byte_b;
   logic         rx_valid_a, rx_valid_b;
   logic         word_ready_a, word_ready_b;
   logic [15:0]  word_a;
   logic [127:0] word_b;
   logic         word_valid_a, word_valid_b;
   logic [7:0]   byte_cnt_a, byte_cnt_b;
   logic         timeout_err_a, timeout_err_b;
   logic         overrun_err_a, overrun_err_b;

   int n_cmp = 0;
   int n_bad = 0;
   int to_pulses = 0;
   int ov_pulses = 0;
   int to0, ov0;

   always #5 clk = ~clk;

   uart_rx_word_assembler #(.NBYTES(2), .TAIL_BYTES(1), .TIMEOUT_CYC(20)) dut_a (
      .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte_a), .rx_valid(rx_valid_a),
      .word_o(word_a), .word_valid(word_valid_a), .word_ready(word_ready_a),
      .byte_cnt(byte_cnt_a), .timeout_err(timeout_err_a), .overrun_err(overrun_err_a));

   uart_rx_word_assembler #(.NBYTES(16), .TAIL_BYTES(0), .TIMEOUT_CYC(0)) dut_b (
      .clk(clk), .reset_n(reset_n), .rx_byte(rx_byte_b), .rx_valid(rx_valid_b),
      .word_o(word_b), .word_valid(word_valid_b), .word_ready(word_ready_b),
      .byte_cnt(byte_cnt_b), .timeout_err(timeout_err_b), .overrun_err(overrun_err_b));

   // Count error pulses on instance a so that each phase can check how many occurred.
   always @(posedge clk) begin
      if (timeout_err_a) to_pulses <= to_pulses + 1;
      if (overrun_err_a) ov_pulses <= ov_pulses + 1;
   end

   task automatic check_val(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send_a(input logic [7:0] b, input int gap);
      rx_byte_a  = b;
      rx_valid_a = 1'b1;
      tick(1);
      rx_valid_a = 1'b0;
      tick(gap);
   endtask

   task automatic frame_a(input logic [7:0] hi, input logic [7:0] lo);
      send_a(hi, 4);
      send_a(lo, 4);
      send_a(8'h0A, 4);
   endtask

   task automatic consume_a();
      word_ready_a = 1'b1;
      tick(1);
      word_ready_a = 1'b0;
   endtask

   initial begin
      reset_n = 1'b0;
      rx_byte_a = 8'h00; rx_valid_a = 1'b0; word_ready_a = 1'b0;
      rx_byte_b = 8'h00; rx_valid_b = 1'b0; word_ready_b = 1'b0;
      tick(3);
      check_val("rst_word", word_a, 128'h0);
      check_val("rst_valid", word_valid_a, 128'h0);
      check_val("rst_cnt", byte_cnt_a, 128'h0);
      check_val("rst_errs", {timeout_err_a, overrun_err_a}, 128'h0);
      reset_n = 1'b1;
      tick(2);

      // Basic frame held unconsumed.
      to0 = to_pulses; ov0 = ov_pulses;
      send_a(8'hA5, 0);
      check_val("cnt_after_b1", byte_cnt_a, 128'd1);
      tick(4);
      send_a(8'h3C, 4);
      send_a(8'h0A, 4);
      check_val("t1_word", word_a, 128'hA53C);
      check_val("t1_valid", word_valid_a, 128'd1);
      check_val("t1_cnt", byte_cnt_a, 128'd0);
      check_val("t1_errs", (to_pulses - to0) + (ov_pulses - ov0), 128'd0);

      // Timeout: 20 idle cycles do not fire, the 21st does.
      to0 = to_pulses;
      send_a(8'h11, 20);
      check_val("t2_no_to_yet", to_pulses - to0, 128'd0);
      tick(1);
      check_val("t2_to_pulse", timeout_err_a, 128'd1);
      tick(3);
      check_val("t2_to_once", to_pulses - to0, 128'd1);
      check_val("t2_cnt", byte_cnt_a, 128'd0);
      check_val("t2_word_kept", word_a, 128'hA53C);
      consume_a();
      check_val("consume_valid", word_valid_a, 128'd0);
      frame_a(8'h22, 8'h33);
      check_val("t2_word", word_a, 128'h2233);

      // A handshake releases the word. A ready while no word is valid is ignored.
      consume_a();
      consume_a();
      check_val("idle_ready_valid", word_valid_a, 128'd0);
      check_val("idle_ready_word", word_a, 128'h2233);

      // Overrun: the second word is dropped and the first word is kept.
      frame_a(8'hA5, 8'h3C);
      ov0 = ov_pulses;
      frame_a(8'h55, 8'h66);
      check_val("t3_ov_once", ov_pulses - ov0, 128'd1);
      check_val("t3_word", word_a, 128'hA53C);
      check_val("t3_valid", word_valid_a, 128'd1);

      // Ready asserted in the COMPLETE cycle: the new word loads with no overrun.
      ov0 = ov_pulses;
      send_a(8'h55, 4);
      send_a(8'h66, 0);
      word_ready_a = 1'b1;
      tick(1);
      word_ready_a = 1'b0;
      check_val("t4_word", word_a, 128'h5566);
      check_val("t4_valid", word_valid_a, 128'd1);
      send_a(8'h0A, 4);
      check_val("t4_no_ov", ov_pulses - ov0, 128'd0);

      // A byte arriving in the very cycle the timeout would fire wins.
      consume_a();
      to0 = to_pulses;
      send_a(8'h77, 20);
      send_a(8'h78, 2);
      check_val("bw_word", word_a, 128'h7778);
      check_val("bw_no_to", to_pulses - to0, 128'd0);
      send_a(8'h0A, 2);

      // Reset mid-frame, then a clean frame.
      send_a(8'hBE, 1);
      reset_n = 1'b0;
      tick(1);
      check_val("mid_rst_word", word_a, 128'h0);
      check_val("mid_rst_valid", word_valid_a, 128'd0);
      check_val("mid_rst_cnt", byte_cnt_a, 128'd0);
      reset_n = 1'b1;
      tick(1);
      frame_a(8'hBE, 8'hEF);
      check_val("rst_frame_word", word_a, 128'hBEEF);

      // Wide word, back-to-back bytes. A byte in the COMPLETE cycle opens the next frame.
      for (int i = 0; i < 16; i++) begin
         rx_byte_b  = 8'(i);
         rx_valid_b = 1'b1;
         tick(1);
      end
      rx_byte_b = 8'hAA;
      tick(1);
      rx_valid_b = 1'b0;
      check_val("wide_word", word_b, 128'h000102030405060708090A0B0C0D0E0F);
      check_val("wide_valid", word_valid_b, 128'd1);
      check_val("wide_next_cnt", byte_cnt_b, 128'd1);
      check_val("wide_no_ov", overrun_err_b, 128'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
